// File: rtl/io_ssd_arb.sv
// Round-robin arbiter sharing the seven-segment display between requesters.
// Holds each grant for a minimum dwell and registers the owner's digit word.
module io_ssd_arb #(
    parameter int          N_REQ = 4,
    parameter logic [15:0] DWELL = 16'd50000,
    parameter int          OWN_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [32*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [OWN_W-1:0]      o_owner,
    output logic                  o_busy,
    output logic [31:0]           o_digits
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;
    localparam int         SW     = OWN_W + 1;

    logic [0:0]       state_q;
    logic [OWN_W-1:0] owner_q;
    logic [OWN_W-1:0] last_q;
    logic [15:0]      cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [31:0]      digits_q;

    logic [OWN_W-1:0] win;
    logic             found;
    logic [SW-1:0]    sum;
    logic [OWN_W-1:0] sel;
    logic             others;
    logic             owner_req;
    logic             release_own;

    // Scan from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        sel   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, last_q} + SW'(k);
            if (sum >= SW'(N_REQ))
                sum = sum - SW'(N_REQ);
            sel = sum[OWN_W-1:0];
            if (i_req[sel]) begin
                win   = sel;
                found = 1'b1;
            end
        end
    end

    assign others      = |(i_req & ~gnt_q);
    assign owner_req   = i_req[owner_q];
    assign release_own = !owner_req || (cnt_q == 16'd0 && others);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            last_q   <= OWN_W'(N_REQ - 1);
            cnt_q    <= 16'd0;
            gnt_q    <= '0;
            digits_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q <= S_OWN;
                        owner_q <= win;
                        last_q  <= win;
                        gnt_q   <= N_REQ'(1) << win;
                        cnt_q   <= DWELL - 16'd1;
                    end
                end
                default: begin
                    digits_q <= i_data[{owner_q, 5'd0} +: 32];
                    if (release_own) begin
                        if (found) begin
                            owner_q <= win;
                            last_q  <= win;
                            gnt_q   <= N_REQ'(1) << win;
                            cnt_q   <= DWELL - 16'd1;
                        end else begin
                            state_q <= S_IDLE;
                            gnt_q   <= '0;
                            cnt_q   <= 16'd0;
                        end
                    end else if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign o_gnt    = gnt_q;
    assign o_owner  = owner_q;
    assign o_busy   = (state_q == S_OWN);
    assign o_digits = digits_q;

endmodule

// File: tb/tb_io_ssd_arb.sv
// Scoreboard bench for io_ssd_arb with DWELL=4 and four requesters.
// Directed cycle vectors push expected outputs; a negedge monitor checks them.
module tb_io_ssd_arb;

    typedef struct {
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [31:0] digits;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_req;
    logic [127:0] i_data;
    logic [3:0]   o_gnt;
    logic [1:0]   o_owner;
    logic         o_busy;
    logic [31:0]  o_digits;

    logic [31:0] w [4];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    assign i_data = {w[3], w[2], w[1], w[0]};

    always #5 clk = ~clk;

    io_ssd_arb #(
        .N_REQ(4),
        .DWELL(16'd4),
        .OWN_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_data(i_data),
        .o_gnt(o_gnt),
        .o_owner(o_owner),
        .o_busy(o_busy),
        .o_digits(o_digits)
    );

    // Drive one cycle of inputs; expectation is for the state after that edge.
    task automatic cyc(input logic r, input logic [3:0] q,
                       input logic [3:0] g, input logic b,
                       input logic [1:0] o, input logic [31:0] d,
                       input string n);
        exp_t e;
        rst   = r;
        i_req = q;
        @(posedge clk);
        #1;
        e.gnt    = g;
        e.busy   = b;
        e.owner  = o;
        e.digits = d;
        e.name   = n;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (o_gnt !== e.gnt) begin
                    errors++;
                    $display("FAIL %s gnt: got %b want %b", e.name, o_gnt, e.gnt);
                end
                checks++;
                if (o_busy !== e.busy) begin
                    errors++;
                    $display("FAIL %s busy: got %b want %b", e.name, o_busy, e.busy);
                end
                checks++;
                if (o_owner !== e.owner) begin
                    errors++;
                    $display("FAIL %s owner: got %0d want %0d", e.name, o_owner, e.owner);
                end
                checks++;
                if (o_digits !== e.digits) begin
                    errors++;
                    $display("FAIL %s digits: got %h want %h", e.name, o_digits, e.digits);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] dexp;
        logic [1:0]  o;
        w[0]  = 32'h1111_0000;
        w[1]  = 32'h2222_0001;
        w[2]  = 32'h1234_5678;
        w[3]  = 32'h4444_0003;
        rst   = 1'b1;
        i_req = 4'b1111;

        // Reset overrides requests; then full contention rotation.
        cyc(1, 4'b1111, 4'b0000, 0, 0, 32'h0, "rst0");
        cyc(1, 4'b1111, 4'b0000, 0, 0, 32'h0, "rst1");
        dexp = 32'h0;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                o = 2'(s % 4);
                cyc(0, 4'b1111, 4'(1) << o, 1, o, dexp, "rr");
                dexp = w[o];
            end
        end

        // Single request, live digit update, hold past dwell.
        cyc(1, 4'b0000, 4'b0000, 0, 0, 32'h0, "rst2");
        cyc(0, 4'b0100, 4'b0100, 1, 2, 32'h0, "single_gnt");
        cyc(0, 4'b0100, 4'b0100, 1, 2, 32'h1234_5678, "single_dig");
        w[2] = 32'hCAFE_0001;
        for (int i = 0; i < 5; i++)
            cyc(0, 4'b0100, 4'b0100, 1, 2, 32'hCAFE_0001, "single_hold");

        // Reset mid-grant with cnt at 2.
        cyc(1, 4'b0000, 4'b0000, 0, 0, 32'h0, "rst3");
        cyc(0, 4'b0100, 4'b0100, 1, 2, 32'h0, "mid_gnt");
        cyc(0, 4'b0100, 4'b0100, 1, 2, 32'hCAFE_0001, "mid_cnt2");
        cyc(1, 4'b0100, 4'b0000, 0, 0, 32'h0, "mid_rst");
        cyc(0, 4'b0000, 4'b0000, 0, 0, 32'h0, "mid_idle");

        // Idle hold and pointer from last+1.
        cyc(0, 4'b1000, 4'b1000, 1, 3, 32'h0, "idle_gnt3");
        cyc(0, 4'b1000, 4'b1000, 1, 3, 32'h4444_0003, "idle_dig3");
        cyc(0, 4'b0000, 4'b0000, 0, 3, 32'h4444_0003, "idle_rel");
        cyc(0, 4'b0000, 4'b0000, 0, 3, 32'h4444_0003, "idle_hold");
        cyc(0, 4'b1010, 4'b0010, 1, 1, 32'h4444_0003, "ptr_gnt1");
        cyc(0, 4'b1010, 4'b0010, 1, 1, 32'h2222_0001, "ptr_dig1");

        // Early release of requester 1 to waiting requester 3.
        cyc(1, 4'b0000, 4'b0000, 0, 0, 32'h0, "rst4");
        cyc(0, 4'b0010, 4'b0010, 1, 1, 32'h0, "early_gnt1");
        cyc(0, 4'b1010, 4'b0010, 1, 1, 32'h2222_0001, "early_keep");
        cyc(0, 4'b1000, 4'b1000, 1, 3, 32'h2222_0001, "early_rel");
        cyc(0, 4'b1010, 4'b1000, 1, 3, 32'h4444_0003, "dwell1");
        cyc(0, 4'b1010, 4'b1000, 1, 3, 32'h4444_0003, "dwell2");
        cyc(0, 4'b1010, 4'b1000, 1, 3, 32'h4444_0003, "dwell3");
        cyc(0, 4'b1010, 4'b0010, 1, 1, 32'h4444_0003, "dwell_exp");

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
